period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 104 ++++++++++
 tb/tb_period_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the period and high time of an asynchronous input in clk cycles.
// One measurement per start; abandons after TIMEOUT cycles without a rising edge.
module period_meter #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time
);

    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_timeout;

    logic             w_rise;
    logic             w_cnt_max;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_cnt_max = (r_cnt == TMO);

    assign busy      = (r_state == ARM) || (r_state == MEASURE);
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign period    = r_period;
    assign high_time = r_high_time;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_s1      <= sig_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARM;
                        r_cnt   <= '0;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_cnt   <= WIDTH'(1);
                        r_hcnt  <= WIDTH'(1);
                    end else if (w_cnt_max) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle still completes the measurement.
                    if (w_rise) begin
                        r_state     <= IDLE;
                        r_period    <= r_cnt;
                        r_high_time <= r_hcnt;
                        r_valid     <= 1'b1;
                    end else if (w_cnt_max) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + WIDTH'(1);
                        r_hcnt <= r_hcnt + WIDTH'(r_s2);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: two instances (TIMEOUT=20 and TIMEOUT=8)
// share the measured signal; each has its own expectation queue and monitor.
module tb_period_meter;

    typedef struct {
        bit          is_to;
        logic [31:0] per;
        logic [31:0] hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        start_a, start_b;
    logic        busy_a, valid_a, timeout_a;
    logic        busy_b, valid_b, timeout_b;
    logic [31:0] period_a, high_a, period_b, high_b;

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    bit   gen_en = 1'b0;
    int   g_hi   = 4;
    int   g_lo   = 4;
    int   busy_cycles;

    always #5 clk = ~clk;

    period_meter #(.WIDTH(32), .TIMEOUT(20)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig), .start(start_a),
        .busy(busy_a), .valid(valid_a), .timeout(timeout_a),
        .period(period_a), .high_time(high_a)
    );

    period_meter #(.WIDTH(32), .TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig), .start(start_b),
        .busy(busy_b), .valid(valid_b), .timeout(timeout_b),
        .period(period_b), .high_time(high_b)
    );

    // Signal generator: high g_hi cycles then low g_lo cycles, starting high.
    initial begin
        int ph;
        ph  = 0;
        sig = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!gen_en) begin
                sig = 1'b0;
                ph  = 0;
            end else begin
                sig = (ph < g_hi);
                ph  = (ph + 1) % (g_hi + g_lo);
            end
        end
    end

    task automatic mon_check(input string nm, input logic v, input logic t,
                             input logic [31:0] p, input logic [31:0] h,
                             input bit use_b);
        exp_t e;
        checks++;
        if (v && t) begin
            errors++;
            $display("FAIL %s_both valid=%0b timeout=%0b required not both", nm, v, t);
        end else if ((use_b ? q_b.size() : q_a.size()) == 0) begin
            errors++;
            $display("FAIL %s_unexpected valid=%0b timeout=%0b required no pulse", nm, v, t);
        end else begin
            e = use_b ? q_b.pop_front() : q_a.pop_front();
            if (e.is_to) begin
                if (!t) begin
                    errors++;
                    $display("FAIL %s_kind got valid (period=%0d) required timeout", nm, p);
                end
            end else if (!v || p !== e.per || h !== e.hi) begin
                errors++;
                $display("FAIL %s_result valid=%0b period=%0d high=%0d required valid period=%0d high=%0d",
                         nm, v, p, h, e.per, e.hi);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (valid_a === 1'b1 || timeout_a === 1'b1)
            mon_check("A", valid_a, timeout_a, period_a, high_a, 1'b0);
        if (valid_b === 1'b1 || timeout_b === 1'b1)
            mon_check("B", valid_b, timeout_b, period_b, high_b, 1'b1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input bit use_b, input bit is_to, input int p, input int h);
        exp_t e;
        e.is_to = is_to;
        e.per   = p;
        e.hi    = h;
        if (use_b) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    task automatic pulse_start(input bit use_b);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic quiesce();
        gen_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done(input bit use_b, input int lim, input string nm);
        int n;
        n = 0;
        while (!(use_b ? (valid_b || timeout_b) : (valid_a || timeout_a)) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) begin
            checks++;
            errors++;
            $display("FAIL %s_wait no pulse within %0d cycles required pulse", nm, lim);
        end
    endtask

    task automatic measure(input bit use_b, input int hi, input int lo, input string nm);
        quiesce();
        push(use_b, 1'b0, hi + lo, hi);
        pulse_start(use_b);
        g_hi   = hi;
        g_lo   = lo;
        gen_en = 1'b1;
        wait_done(use_b, 80, nm);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_timeout_a", timeout_a, 0);
        chk("rst_period_a", period_a, 0);
        chk("rst_high_a", high_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;

        measure(1'b0, 4, 4, "duty_4_4");
        chk("duty_4_4_period_hold", period_a, 8);
        measure(1'b0, 3, 7, "duty_3_7");

        // Timeout: input held low, TIMEOUT=20.
        quiesce();
        push(1'b0, 1'b1, 0, 0);
        pulse_start(1'b0);
        busy_cycles = 0;
        while (busy_a && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        chk("timeout_busy_cycles", busy_cycles, 21);
        repeat (5) @(negedge clk);
        chk("timeout_period_kept", period_a, 10);
        chk("timeout_high_kept", high_a, 3);

        // Reset in the middle of a measurement.
        quiesce();
        pulse_start(1'b0);
        g_hi   = 4;
        g_lo   = 4;
        gen_en = 1'b1;
        repeat (7) @(negedge clk);
        chk("midrst_busy_before", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_period", period_a, 0);
        chk("midrst_high", high_a, 0);
        repeat (30) @(negedge clk);

        // Start while busy is ignored; start on the valid cycle is accepted.
        quiesce();
        push(1'b0, 1'b0, 8, 4);
        pulse_start(1'b0);
        g_hi   = 4;
        g_lo   = 4;
        gen_en = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start(1'b0);
        wait_done(1'b0, 40, "busy_start");
        push(1'b0, 1'b0, 8, 4);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("restart_on_valid_busy", busy_a, 1);
        wait_done(1'b0, 40, "restart");
        repeat (20) @(negedge clk);

        // Period exactly equal to TIMEOUT=8 completes normally.
        measure(1'b1, 4, 4, "boundary");
        chk("boundary_period", period_b, 8);
        gen_en = 1'b0;

        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
